// File: rtl/avr_cpu_fetch_if.sv
// Fetch <-> decoder/execute/ROM signal bundle for the AVR fetch sequencer.
// master = fetch unit, slave = decoder/execute/ROM side.
interface avr_cpu_fetch_if #(
   parameter int PC_WIDTH = 12
);
   logic [PC_WIDTH-1:0] prog_addr;
   logic [15:0]         prog_data;
   logic [15:0]         opcode;
   logic                cycle;
   logic                exec_valid;
   logic [PC_WIDTH-1:0] exec_pc;
   logic                hold;
   logic [15:0]         pc_update;
   logic                stack_read;
   logic [PC_WIDTH-1:0] ret_addr;
   logic [PC_WIDTH-1:0] push_addr;
   logic                lpm_access;
   logic [15:0]         z_addr;
   logic [7:0]          lpm_data;
   logic                branch_taken;
   logic                skip;

   modport master (
      output prog_addr, opcode, cycle, exec_valid, exec_pc, push_addr, lpm_data,
      input  prog_data, hold, pc_update, stack_read, ret_addr, lpm_access,
             z_addr, branch_taken, skip
   );

   modport slave (
      input  prog_addr, opcode, cycle, exec_valid, exec_pc, push_addr, lpm_data,
      output prog_data, hold, pc_update, stack_read, ret_addr, lpm_access,
             z_addr, branch_taken, skip
   );
endinterface

// File: rtl/avr_cpu_fetch.sv
// AVR instruction fetch sequencer: owns the PC, inserts bubbles for taken
// branches and skips, sequences two-cycle instructions and steals the ROM port for LPM.
module avr_cpu_fetch #(
   parameter int PC_WIDTH = 12
) (
   input  logic           clk,
   input  logic           reset,
   avr_cpu_fetch_if.master bus
);

   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } phase_e;

   phase_e              phase_q, phase_d;
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0] exec_pc_q, exec_pc_d;
   logic                valid_q, valid_d;
   logic [15:0]         ir_hold_q, ir_hold_d;
   logic                lpm_lo_q, lpm_lo_d;

   logic                cycle;
   logic                exec_valid;
   logic [15:0]         opcode;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] fetch_pc_inc;
   logic                lpm_steal;
   logic                unused_ok;

   assign unused_ok = ^{bus.pc_update[15:PC_WIDTH], bus.z_addr[15:PC_WIDTH+1]};

   always_comb begin
      cycle        = (phase_q == PH_SECOND);
      exec_valid   = valid_q | cycle;
      opcode       = 16'h0000;
      if (cycle) begin
         opcode = ir_hold_q;
      end else if (valid_q) begin
         opcode = bus.prog_data;
      end
      target       = exec_pc_q + PC_WIDTH'(1) + bus.pc_update[PC_WIDTH-1:0];
      fetch_pc_inc = fetch_pc_q + PC_WIDTH'(1);
      // An LPM only owns the ROM port while a real instruction sits in cycle 0.
      lpm_steal    = !cycle && valid_q && bus.lpm_access;
   end

   always_comb begin
      bus.cycle      = cycle;
      bus.exec_valid = exec_valid;
      bus.opcode     = opcode;
      bus.exec_pc    = exec_pc_q;
      bus.push_addr  = exec_pc_q + PC_WIDTH'(1);
      bus.prog_addr  = lpm_steal ? bus.z_addr[PC_WIDTH:1] : fetch_pc_q;
      bus.lpm_data   = 8'h00;
      if (cycle) begin
         bus.lpm_data = lpm_lo_q ? bus.prog_data[7:0] : bus.prog_data[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q    <= PH_FIRST;
         fetch_pc_q <= '0;
         exec_pc_q  <= '0;
         valid_q    <= 1'b0;
         ir_hold_q  <= 16'h0000;
         lpm_lo_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         fetch_pc_q <= fetch_pc_d;
         exec_pc_q  <= exec_pc_d;
         valid_q    <= valid_d;
         ir_hold_q  <= ir_hold_d;
         lpm_lo_q   <= lpm_lo_d;
      end
   end

   always_comb begin
      phase_d    = phase_q;
      fetch_pc_d = fetch_pc_q;
      exec_pc_d  = exec_pc_q;
      valid_d    = valid_q;
      ir_hold_d  = ir_hold_q;
      lpm_lo_d   = lpm_lo_q;

      if (cycle) begin
         // The ROM was re-addressed with fetch_pc during cycle 1, so the
         // instruction arriving next is the one at fetch_pc.
         phase_d    = PH_FIRST;
         valid_d    = 1'b1;
         exec_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_inc;
      end else if (exec_valid && bus.hold) begin
         phase_d    = PH_SECOND;
         ir_hold_d  = opcode;
         fetch_pc_d = bus.stack_read ? bus.ret_addr : target;
         if (bus.lpm_access) begin
            lpm_lo_d = ~bus.z_addr[0];
         end
      end else if (valid_q && (bus.pc_update != 16'h0000) && bus.branch_taken) begin
         fetch_pc_d = target;
         valid_d    = 1'b0;
      end else if (valid_q && bus.skip) begin
         valid_d    = 1'b0;
         exec_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_inc;
      end else begin
         exec_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_inc;
         valid_d    = 1'b1;
      end
   end

endmodule

// File: tb/tb_avr_cpu_fetch.sv
// Directed bench for avr_cpu_fetch: a registered ROM model plus a per-cycle
// table of decoder/execute inputs and hand-computed fetch outputs.
module tb_avr_cpu_fetch;

   localparam int PC_WIDTH = 12;

   typedef struct {
      logic        rst;
      logic        hold;
      logic [15:0] pc_update;
      logic        stack_read;
      logic [11:0] ret_addr;
      logic        lpm_access;
      logic [15:0] z_addr;
      logic        br;
      logic        skip;
      logic [15:0] exp_opcode;
      logic        exp_cycle;
      logic        exp_valid;
      logic [11:0] exp_pc;
      logic [11:0] exp_paddr;
      logic [7:0]  exp_lpm;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [15:0] rom [0:4095];
   int          compared;
   int          failed;
   vec_t        vecs [$];

   avr_cpu_fetch_if #(.PC_WIDTH(PC_WIDTH)) bus ();

   avr_cpu_fetch #(.PC_WIDTH(PC_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

   function automatic vec_t v(input logic rst, input logic hold, input logic [15:0] pcu,
                              input logic sr, input logic [11:0] ra, input logic la,
                              input logic [15:0] z, input logic br, input logic sk,
                              input logic [15:0] op, input logic cyc, input logic ev,
                              input logic [11:0] epc, input logic [11:0] pa,
                              input logic [7:0] lpm);
      vec_t r;
      r.rst = rst; r.hold = hold; r.pc_update = pcu; r.stack_read = sr; r.ret_addr = ra;
      r.lpm_access = la; r.z_addr = z; r.br = br; r.skip = sk;
      r.exp_opcode = op; r.exp_cycle = cyc; r.exp_valid = ev; r.exp_pc = epc;
      r.exp_paddr = pa; r.exp_lpm = lpm;
      return r;
   endfunction

   function automatic vec_t n(input logic [15:0] op, input logic ev,
                              input logic [11:0] epc, input logic [11:0] pa);
      return v(0, 0, 16'h0, 0, 12'h0, 0, 16'h0, 0, 0, op, 0, ev, epc, pa, 8'h00);
   endfunction

   task automatic applyStimulus(input vec_t t);
      reset            = t.rst;
      bus.hold         = t.hold;
      bus.pc_update    = t.pc_update;
      bus.stack_read   = t.stack_read;
      bus.ret_addr     = t.ret_addr;
      bus.lpm_access   = t.lpm_access;
      bus.z_addr       = t.z_addr;
      bus.branch_taken = t.br;
      bus.skip         = t.skip;
   endtask

   task automatic cmp(input string name, input int step, input logic [15:0] act,
                      input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
      end
   endtask

   task automatic checkOutput(input int step, input vec_t t);
      logic [11:0] exp_push;
      exp_push = t.exp_pc + 12'd1;
      cmp("opcode",     step, bus.opcode,               t.exp_opcode);
      cmp("cycle",      step, {15'h0, bus.cycle},       {15'h0, t.exp_cycle});
      cmp("exec_valid", step, {15'h0, bus.exec_valid},  {15'h0, t.exp_valid});
      cmp("exec_pc",    step, {4'h0, bus.exec_pc},      {4'h0, t.exp_pc});
      cmp("prog_addr",  step, {4'h0, bus.prog_addr},    {4'h0, t.exp_paddr});
      cmp("lpm_data",   step, {8'h0, bus.lpm_data},     {8'h0, t.exp_lpm});
      cmp("push_addr",  step, {4'h0, bus.push_addr},    {4'h0, exp_push});
   endtask

   task automatic runStep(input int step, input vec_t t);
      @(negedge clk);
      applyStimulus(t);
      #1;
      checkOutput(step, t);
   endtask

   initial begin
      compared = 0;
      failed   = 0;
      for (int i = 0; i < 4096; i++) rom[i] = 16'h1000 + 16'(i);
      rom[0] = 16'h0C01; rom[1] = 16'h0C02; rom[2] = 16'h0000; rom[3] = 16'h0C03;
      rom[5] = 16'hCFFE; rom[12'h080] = 16'hABCD;

      // Straight line after reset, then RJMP -2 at 5 and a forward jump to 10.
      vecs.push_back(n(16'h0000, 0, 12'd0, 12'd0));
      vecs.push_back(n(16'h0C01, 1, 12'd0, 12'd1));
      vecs.push_back(n(16'h0C02, 1, 12'd1, 12'd2));
      vecs.push_back(n(16'h0000, 1, 12'd2, 12'd3));
      vecs.push_back(n(16'h0C03, 1, 12'd3, 12'd4));
      vecs.push_back(n(16'h1004, 1, 12'd4, 12'd5));
      vecs.push_back(v(0, 1, 16'hFFFE, 0, 12'd0, 0, 16'h0, 0, 0, 16'hCFFE, 0, 1, 12'd5, 12'd6, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'hCFFE, 1, 1, 12'd5, 12'd4, 8'h10));
      vecs.push_back(v(0, 1, 16'h0005, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1004, 0, 1, 12'd4, 12'd5, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1004, 1, 1, 12'd4, 12'd10, 8'hCF));
      // Taken branch at 10 (+5 -> 16); decoder inputs during the bubble are ignored.
      vecs.push_back(v(0, 0, 16'h0005, 0, 12'd0, 0, 16'h0, 1, 0, 16'h100A, 0, 1, 12'd10, 12'd11, 8'h00));
      vecs.push_back(v(0, 1, 16'h0005, 0, 12'd0, 0, 16'h0, 1, 1, 16'h0000, 0, 0, 12'd10, 12'd16, 8'h00));
      vecs.push_back(v(0, 0, 16'h0005, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1010, 0, 1, 12'd16, 12'd17, 8'h00));
      vecs.push_back(n(16'h1011, 1, 12'd17, 12'd18));
      vecs.push_back(n(16'h1012, 1, 12'd18, 12'd19));
      vecs.push_back(n(16'h1013, 1, 12'd19, 12'd20));
      // Skip at 20 squashes 21.
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 1, 16'h1014, 0, 1, 12'd20, 12'd21, 8'h00));
      vecs.push_back(n(16'h0000, 0, 12'd21, 12'd22));
      vecs.push_back(v(0, 1, 16'h0007, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1016, 0, 1, 12'd22, 12'd23, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1016, 1, 1, 12'd22, 12'd30, 8'h10));
      // RCALL at 30 (push 31), then RET to 31.
      vecs.push_back(v(0, 1, 16'h0005, 0, 12'd0, 0, 16'h0, 0, 0, 16'h101E, 0, 1, 12'd30, 12'd31, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'h101E, 1, 1, 12'd30, 12'd36, 8'h10));
      vecs.push_back(v(0, 1, 16'h0000, 1, 12'd31, 0, 16'h0, 0, 0, 16'h1024, 0, 1, 12'd36, 12'd37, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'h1024, 1, 1, 12'd36, 12'd31, 8'h10));
      // LPM high byte, LPM low byte, then LPM aborted by reset in cycle 1.
      vecs.push_back(v(0, 1, 16'h0000, 0, 12'd0, 1, 16'h0101, 0, 0, 16'h101F, 0, 1, 12'd31, 12'h080, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0101, 0, 0, 16'h101F, 1, 1, 12'd31, 12'd32, 8'hAB));
      vecs.push_back(v(0, 1, 16'h0000, 0, 12'd0, 1, 16'h0100, 0, 0, 16'h1020, 0, 1, 12'd32, 12'h080, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0100, 0, 0, 16'h1020, 1, 1, 12'd32, 12'd33, 8'hCD));
      vecs.push_back(v(0, 1, 16'h0000, 0, 12'd0, 1, 16'h0101, 0, 0, 16'h1021, 0, 1, 12'd33, 12'h080, 8'h00));
      vecs.push_back(v(1, 0, 16'h0000, 0, 12'd0, 0, 16'h0101, 0, 0, 16'h1021, 1, 1, 12'd33, 12'd34, 8'hAB));
      vecs.push_back(n(16'h0000, 0, 12'd0, 12'd0));
      // Jump backwards from 0 wraps to 4094, then fetch_pc wraps 4095 -> 0.
      vecs.push_back(v(0, 1, 16'hFFFD, 0, 12'd0, 0, 16'h0, 0, 0, 16'h0C01, 0, 1, 12'd0, 12'd1, 8'h00));
      vecs.push_back(v(0, 0, 16'h0000, 0, 12'd0, 0, 16'h0, 0, 0, 16'h0C01, 1, 1, 12'd0, 12'd4094, 8'h0C));
      vecs.push_back(n(16'h1FFE, 1, 12'd4094, 12'd4095));
      vecs.push_back(n(16'h1FFF, 1, 12'd4095, 12'd0));
      vecs.push_back(n(16'h0C01, 1, 12'd0, 12'd1));

      applyStimulus(n(16'h0, 0, 12'd0, 12'd0));
      reset = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) runStep(i, vecs[i]);

      // Taken branch at 1 with offset -3 wraps the target to 4095.
      $display("[TB] hand sequence: backward taken branch with wrap");
      runStep(100, v(0, 0, 16'hFFFD, 0, 12'd0, 0, 16'h0, 1, 0, 16'h0C02, 0, 1, 12'd1, 12'd2, 8'h00));
      runStep(101, n(16'h0000, 0, 12'd1, 12'd4095));
      runStep(102, n(16'h1FFF, 1, 12'd4095, 12'd0));
      runStep(103, n(16'h0C01, 1, 12'd0, 12'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
